// File: rtl/reg_file_alu_pkg.sv
// Shared types for the register-file/ALU execute core: ALU opcodes and the
// bit positions of the {N,Z,C,V} status flags.
package reg_file_alu_pkg;

  typedef enum logic [2:0] {
    OP_PASS_B = 3'd0,
    OP_ADD    = 3'd1,
    OP_SUB    = 3'd2,
    OP_AND    = 3'd3,
    OP_OR     = 3'd4,
    OP_XOR    = 3'd5,
    OP_SHL    = 3'd6,
    OP_SHR    = 3'd7
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/reg_file_alu_pipe_alu_core.sv
// Combinational 8-operation ALU producing a DATA_W result and {N,Z,C,V}.
// C on SUB means "no borrow" (A >= B unsigned).
module alu_core
  import reg_file_alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags
);

  logic [DATA_W:0] sum_s;
  logic [DATA_W:0] diff_s;
  logic            carry_s;
  logic            ovf_s;

  // operation select plus flag generation
  always_comb begin
    sum_s   = {1'b0, a} + {1'b0, b};
    diff_s  = {1'b0, a} - {1'b0, b};
    result  = b;
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (op)
      OP_PASS_B: result = b;
      OP_ADD: begin
        result  = sum_s[DATA_W-1:0];
        carry_s = sum_s[DATA_W];
        ovf_s   = (a[DATA_W-1] == b[DATA_W-1]) && (sum_s[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        result  = diff_s[DATA_W-1:0];
        carry_s = ~diff_s[DATA_W];
        ovf_s   = (a[DATA_W-1] != b[DATA_W-1]) && (diff_s[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL: begin
        result  = {a[DATA_W-2:0], 1'b0};
        carry_s = a[DATA_W-1];
      end
      OP_SHR: begin
        result  = {1'b0, a[DATA_W-1:1]};
        carry_s = a[0];
      end
      default: begin
        result  = b;
        carry_s = 1'b0;
        ovf_s   = 1'b0;
      end
    endcase
    flags         = 4'b0000;
    flags[FLAG_N] = result[DATA_W-1];
    flags[FLAG_Z] = (result == {DATA_W{1'b0}});
    flags[FLAG_C] = carry_s;
    flags[FLAG_V] = ovf_s;
  end

endmodule

// File: rtl/reg_file_alu_pipe.sv
// Two-stage register file + ALU: stage 1 reads/latches operands, stage 2
// computes, registers result/flags and writes back, with result forwarding.
module reg_file_alu_pipe
  import reg_file_alu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [ADDR_W-1:0] WA,
  input  logic              RegWrite,
  input  logic              ALUSrc,
  input  logic [2:0]        ALUControl,
  input  logic [DATA_W-1:0] external_data_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] ALUResult,
  output logic [3:0]        flags
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs_r [NREGS];
  logic [DATA_W-1:0] s1_a_r;
  logic [DATA_W-1:0] s1_b_r;
  alu_op_e           s1_op_r;
  logic [ADDR_W-1:0] s1_wa_r;
  logic              s1_we_r;
  logic              s1_valid_r;
  logic [DATA_W-1:0] alu_result_s;
  logic [3:0]        alu_flags_s;
  logic              wb_en_s;
  logic [DATA_W-1:0] rd_a_s;
  logic [DATA_W-1:0] rd_b_s;
  logic [DATA_W-1:0] op_b_s;
  logic [DATA_W-1:0] result_r;
  logic [3:0]        flags_r;
  logic              out_valid_r;

  // Reads see the value being written back this cycle, so dependent
  // instructions can issue back-to-back.
  function automatic logic [DATA_W-1:0] rd_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] reg_val,
    input logic              wb_en,
    input logic [ADDR_W-1:0] wb_addr,
    input logic [DATA_W-1:0] wb_val
  );
    if (ZERO_REG && (addr == {ADDR_W{1'b0}})) return {DATA_W{1'b0}};
    else if (wb_en && (wb_addr == addr))      return wb_val;
    else                                      return reg_val;
  endfunction

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .a      (s1_a_r),
    .b      (s1_b_r),
    .op     (s1_op_r),
    .result (alu_result_s),
    .flags  (alu_flags_s)
  );

  // write-back enable, excluding the hardwired-zero register
  always_comb begin
    if (s1_valid_r && s1_we_r && !(ZERO_REG && (s1_wa_r == {ADDR_W{1'b0}})))
      wb_en_s = 1'b1;
    else
      wb_en_s = 1'b0;
  end

  // operand read ports with forwarding and immediate select
  always_comb begin
    rd_a_s = rd_port(RA1, regs_r[RA1], wb_en_s, s1_wa_r, alu_result_s);
    rd_b_s = rd_port(RA2, regs_r[RA2], wb_en_s, s1_wa_r, alu_result_s);
    if (ALUSrc) op_b_s = external_data_in;
    else        op_b_s = rd_b_s;
  end

  // stage 1 operand/control latch
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_a_r     <= {DATA_W{1'b0}};
      s1_b_r     <= {DATA_W{1'b0}};
      s1_op_r    <= OP_PASS_B;
      s1_wa_r    <= {ADDR_W{1'b0}};
      s1_we_r    <= 1'b0;
      s1_valid_r <= 1'b0;
    end else if (in_valid) begin
      s1_a_r     <= rd_a_s;
      s1_b_r     <= op_b_s;
      s1_op_r    <= alu_op_e'(ALUControl);
      s1_wa_r    <= WA;
      s1_we_r    <= RegWrite;
      s1_valid_r <= 1'b1;
    end else begin
      s1_valid_r <= 1'b0;
    end
  end

  // stage 2 result/flag registers; hold when no instruction completes
  always_ff @(posedge clk) begin
    if (!reset) begin
      result_r    <= {DATA_W{1'b0}};
      flags_r     <= 4'b0000;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        result_r <= alu_result_s;
        flags_r  <= alu_flags_s;
      end
    end
  end

  // register file write-back
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_r[i] <= {DATA_W{1'b0}};
    end else if (wb_en_s) begin
      regs_r[s1_wa_r] <= alu_result_s;
    end
  end

  assign out_valid = out_valid_r;
  assign ALUResult = result_r;
  assign flags     = flags_r;

endmodule

// File: tb/tb_reg_file_alu_pipe.sv
// Directed bench for reg_file_alu_pipe (DATA_W=8, ADDR_W=4, ZERO_REG=1).
module tb_reg_file_alu_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] RA1, RA2, WA;
  logic       RegWrite, ALUSrc;
  logic [2:0] ALUControl;
  logic [7:0] external_data_in;
  logic       out_valid;
  logic [7:0] ALUResult;
  logic [3:0] flags;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  reg_file_alu_pipe #(.DATA_W(8), .ADDR_W(4), .ZERO_REG(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .RA1(RA1), .RA2(RA2),
    .WA(WA), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .ALUControl(ALUControl),
    .external_data_in(external_data_in), .out_valid(out_valid),
    .ALUResult(ALUResult), .flags(flags)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] ra1, input logic [3:0] ra2,
                       input logic src, input logic [7:0] ext, input logic we, input logic [3:0] wa);
    in_valid = 1'b1; ALUControl = op; RA1 = ra1; RA2 = ra2;
    ALUSrc = src; external_data_in = ext; RegWrite = we; WA = wa;
  endtask

  task automatic idle();
    in_valid = 1'b0; RegWrite = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [7:0] res, input logic [3:0] fl);
    checks_total++;
    if (out_valid !== 1'b1) $display("FAIL %s out_valid got %b exp 1", name, out_valid);
    else checks_passed++;
    checks_total++;
    if (ALUResult !== res) $display("FAIL %s ALUResult got %h exp %h", name, ALUResult, res);
    else checks_passed++;
    checks_total++;
    if (flags !== fl) $display("FAIL %s flags got %b exp %b", name, flags, fl);
    else checks_passed++;
  endtask

  task automatic test_reset();
    reset = 1'b0; idle(); RA1 = 4'd0; RA2 = 4'd0; WA = 4'd0; ALUSrc = 1'b0;
    ALUControl = 3'd0; external_data_in = 8'h00;
    step(); step();
    checks_total++;
    if (out_valid !== 1'b0 || ALUResult !== 8'h00 || flags !== 4'b0000)
      $display("FAIL reset_state got v=%b r=%h f=%b exp 0/00/0000", out_valid, ALUResult, flags);
    else checks_passed++;
    reset = 1'b1;
  endtask

  task automatic test_load();
    issue(3'd0, 4'd0, 4'd0, 1'b1, 8'h05, 1'b1, 4'd5); step();
    issue(3'd0, 4'd0, 4'd0, 1'b1, 8'h04, 1'b1, 4'd4); step();
    expect_out("load_r5", 8'h05, 4'b0000);
    idle(); step();
    expect_out("load_r4", 8'h04, 4'b0000);
    step();
    checks_total++;
    if (out_valid !== 1'b0 || ALUResult !== 8'h04)
      $display("FAIL load_hold got v=%b r=%h exp 0/04", out_valid, ALUResult);
    else checks_passed++;
  endtask

  task automatic test_add_sub();
    issue(3'd1, 4'd5, 4'd4, 1'b0, 8'h00, 1'b0, 4'd0); step();
    issue(3'd2, 4'd5, 4'd4, 1'b0, 8'h00, 1'b0, 4'd0); step();
    expect_out("add_r5_r4", 8'h09, 4'b0000);
    issue(3'd2, 4'd4, 4'd5, 1'b0, 8'h00, 1'b0, 4'd0); step();
    expect_out("sub_r5_r4", 8'h01, 4'b0010);
    idle(); step();
    expect_out("sub_r4_r5", 8'hFF, 4'b1000);
  endtask

  task automatic test_forwarding();
    issue(3'd0, 4'd0, 4'd0, 1'b1, 8'h7F, 1'b1, 4'd1); step();
    issue(3'd1, 4'd1, 4'd0, 1'b1, 8'h01, 1'b1, 4'd2); step();
    expect_out("fwd_load_7f", 8'h7F, 4'b0000);
    issue(3'd1, 4'd2, 4'd2, 1'b0, 8'h00, 1'b0, 4'd7); step();
    expect_out("fwd_add_r1", 8'h80, 4'b1001);
    idle(); step();
    expect_out("fwd_add_r2r2", 8'h00, 4'b0111);
  endtask

  task automatic test_zero_reg_logic();
    issue(3'd0, 4'd0, 4'd0, 1'b1, 8'hAA, 1'b1, 4'd0); step();
    issue(3'd1, 4'd0, 4'd0, 1'b1, 8'h03, 1'b0, 4'd0); step();
    expect_out("zr_load_aa", 8'hAA, 4'b1000);
    issue(3'd3, 4'd4, 4'd0, 1'b1, 8'h0C, 1'b0, 4'd0); step();
    expect_out("zr_add_r0", 8'h03, 4'b0000);
    issue(3'd4, 4'd4, 4'd0, 1'b1, 8'h0C, 1'b0, 4'd0); step();
    expect_out("and_0c", 8'h04, 4'b0000);
    issue(3'd5, 4'd4, 4'd0, 1'b1, 8'h0C, 1'b0, 4'd0); step();
    expect_out("or_0c", 8'h0C, 4'b0000);
    issue(3'd3, 4'd4, 4'd0, 1'b1, 8'h00, 1'b0, 4'd0); step();
    expect_out("xor_0c", 8'h08, 4'b0000);
    idle(); step();
    expect_out("and_00", 8'h00, 4'b0100);
  endtask

  task automatic test_shifts();
    issue(3'd0, 4'd0, 4'd0, 1'b1, 8'h81, 1'b1, 4'd3); step();
    issue(3'd6, 4'd3, 4'd0, 1'b0, 8'h00, 1'b0, 4'd0); step();
    expect_out("load_81", 8'h81, 4'b1000);
    issue(3'd7, 4'd3, 4'd0, 1'b0, 8'h00, 1'b0, 4'd0); step();
    expect_out("shl_81", 8'h02, 4'b0010);
    idle(); step();
    expect_out("shr_81", 8'h40, 4'b0010);
  endtask

  task automatic test_reset_mid_op();
    issue(3'd1, 4'd5, 4'd4, 1'b0, 8'h00, 1'b1, 4'd6); step();
    idle(); reset = 1'b0; step();
    checks_total++;
    if (out_valid !== 1'b0 || ALUResult !== 8'h00)
      $display("FAIL midrst_discard got v=%b r=%h exp 0/00", out_valid, ALUResult);
    else checks_passed++;
    reset = 1'b1; step();
    checks_total++;
    if (out_valid !== 1'b0) $display("FAIL midrst_release out_valid got %b exp 0", out_valid);
    else checks_passed++;
    issue(3'd1, 4'd6, 4'd0, 1'b1, 8'h00, 1'b0, 4'd0); step();
    idle(); step();
    expect_out("midrst_r6", 8'h00, 4'b0100);
  endtask

  initial begin
    test_reset();
    test_load();
    test_add_sub();
    test_forwarding();
    test_zero_reg_logic();
    test_shifts();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
